mdu: RTL
========

# mdu

Multiply/divide unit placed beside the ALU in the datapath. It takes the same two GRF read operands as the ALU, runs MIPS multiply and divide operations over a fixed multi-cycle latency, and holds the results in HI/LO. It drives `busy` so the controller can stall, and drives `mdu_out` into a spare input of the GRF write-data multiplexer for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD group); legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: qualifies `mdu_op`; all state-changing ops act only when `start`=1.
- `mdu_op` input 4: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB; 12–15 NOP.
- `a` input 32: GRF[rs].
- `b` input 32: GRF[rt].
- `busy` output 1: operation in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `mdu_out` output 32: combinational; `hi` when `mdu_op`=5, otherwise `lo`.

## Operation
- States: IDLE (`busy`=0, count=0) and RUN (`busy`=1, count 1..15), with a 4-bit down-counter.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU/MADD*:
  - compute the 64-bit result from `a`/`b` at that edge into a pending register;
  - count ← MULT_CYCLES or DIV_CYCLES; go to RUN.
- MULT: {HI,LO} = signed a×b. MULTU: unsigned a×b.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of `a`. DIVU: unsigned quotient/remainder.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (`b`=0): full DIV_CYCLES busy; HI/LO left unchanged at completion.
- RUN, count>1: count decrements each edge.
- RUN, count=1: at that edge HI/LO ← pending, count ← 0, return to IDLE.
- MTHI/MTLO with `start`=1 in IDLE: HI or LO ← `a` at that edge; zero latency; `busy` stays 0.
- Any `start` while `busy`=1 is ignored. This covers all ops; the controller must stall.
- MFHI/MFLO are pure reads and need no `start`. During RUN they return the old HI/LO.
- NOP and undefined encodings: no state change.

## Timing
- Reset (asserted low, asynchronous): HI=0, LO=0, `busy`=0, count=0, pending=0, so `mdu_out`=0. Deassertion is synchronous to `clk` externally.
- Reset mid-RUN aborts the operation immediately; the pending result is discarded.
- Start accepted at edge E: `busy`=1 from E through E+N−1, where N is the latency parameter. At edge E+N, HI/LO are updated and `busy` falls together.
- Back-to-back operations: a new `start` is accepted at edge E+N, i.e. the first cycle with `busy`=0.
- MTHI/MTLO are visible on `hi`/`lo` the cycle after their edge.
- `busy` is driven from a register and has no combinational path from inputs.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 9/10/11 are live, with MULT_CYCLES latency;
  - MADD: {HI,LO} ← {HI,LO} + signed a×b. MADDU: + unsigned a×b. MSUB: − signed a×b. All modulo 2^64.
  - HI/LO are sampled at the start edge; they cannot change during RUN.
- `MDU_MADD_EN` undefined: ops 9–11 are NOPs and no accumulator adder is built.

## Test plan
- Reset low mid-DIV (cycle 3 of 10) → `busy`=0, `hi`=`lo`=0 immediately. After release, a new MULT is accepted.
- MULT a=0xFFFFFFFF, b=2 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=−7 (0xFFFFFFF9), b=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 → LO=3, HI=1.
- Start MULT, then pulse MTLO a=0x1234 with `start` during `busy` → MTLO is ignored; LO holds the MULT result when `busy` falls.
- DIV by b=0 with HI=0xAA, LO=0xBB → `busy` runs 10 cycles; HI=0xAA, LO=0xBB afterwards. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- `MDU_MADD_EN`: MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 → HI=1, LO=0. Without the macro, the same sequence → HI=0, LO=0xFFFFFFFF and `busy` never rises.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and a busy stall flag.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB accumulate ops (9..11).
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, sq, sr, quot_s, rem_s, quot_u, rem_u;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally.
  assign div_b  = (b == '0) ? 32'd1 : b;
  assign abs_a  = a[31] ? -a : a;
  assign abs_b  = div_b[31] ? -div_b : div_b;
  assign sq     = abs_a / abs_b;
  assign sr     = abs_a % abs_b;
  assign quot_s = (a[31] ^ div_b[31]) ? -sq : sq;
  assign rem_s  = a[31] ? -sr : sr;
  assign quot_u = a / div_b;
  assign rem_u  = a % div_b;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`else
  // Ops 9..11 fall through to the NOP default; no accumulator is built.
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              pend_d = prod_s; wr_d = 1'b1;
              cnt_d = 4'(MULT_CYCLES); state_d = RUN;
            end
            OP_MULTU: begin
              pend_d = prod_u; wr_d = 1'b1;
              cnt_d = 4'(MULT_CYCLES); state_d = RUN;
            end
            OP_DIV: begin
              pend_d = {rem_s, quot_s}; wr_d = (b != '0);
              cnt_d = 4'(DIV_CYCLES); state_d = RUN;
            end
            OP_DIVU: begin
              pend_d = {rem_u, quot_u}; wr_d = (b != '0);
              cnt_d = 4'(DIV_CYCLES); state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              pend_d = acc + prod_s; wr_d = 1'b1;
              cnt_d = 4'(MULT_CYCLES); state_d = RUN;
            end
            OP_MADDU: begin
              pend_d = acc + prod_u; wr_d = 1'b1;
              cnt_d = 4'(MULT_CYCLES); state_d = RUN;
            end
            OP_MSUB: begin
              pend_d = acc - prod_s; wr_d = 1'b1;
              cnt_d = 4'(MULT_CYCLES); state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          if (wr_q) {hi_d, lo_d} = pend_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_out = (mdu_op == OP_MFHI) ? hi_q : lo_q;

endmodule
